// File: rtl/nmi_button_if.sv
// Signal bundle between the front-panel NMI button pin and the conditioner.
// master = conditioner side, slave = consumer/driver of the raw pin.
interface nmi_button_if;
  logic button_raw_n;
  logic nmi_button_n;
  logic press_pulse;
  logic release_pulse;
  logic mrst_req_n;

  modport master (
    input  button_raw_n,
    output nmi_button_n,
    output press_pulse,
    output release_pulse,
    output mrst_req_n
  );

  modport slave (
    output button_raw_n,
    input  nmi_button_n,
    input  press_pulse,
    input  release_pulse,
    input  mrst_req_n
  );
endinterface

// File: rtl/nmi_button_conditioner.sv
// Synchronises, debounces and edge-detects the NMI push-button; long-hold master-reset
// request is built only when NMI_LONGPRESS_EN is defined.
module nmi_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic         clk,
  input  logic         rst_n,
  nmi_button_if.master btn
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync_n_q, sync_n_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          nmi_button_n_q, nmi_button_n_d;
  logic          press_pulse_q, press_pulse_d;
  logic          release_pulse_q, release_pulse_d;
  logic          mrst_req_n_q, mrst_req_n_d;
  logic          differ, accept, acc_fall, acc_rise;

  always_comb begin
    sync1_d  = btn.button_raw_n;
    sync_n_d = sync1_q;
  end

  // Any sample matching the current level restarts the count.
  always_comb begin
    differ         = (sync_n_q != nmi_button_n_q);
    accept         = differ && (dcnt_q == DCNT_LAST);
    acc_fall       = accept && !sync_n_q;
    acc_rise       = accept && sync_n_q;
    dcnt_d         = (differ && !accept) ? dcnt_q + DW'(1) : '0;
    nmi_button_n_d = accept ? sync_n_q : nmi_button_n_q;
  end

`ifdef NMI_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          hold_done;

  // Saturating hold counter; frozen once LONG is reached.
  always_comb begin
    hold_done = (hcnt_q == HCNT_LAST);
    hcnt_d    = hcnt_q;
    if (state_q == ST_RELEASED) begin
      hcnt_d = '0;
    end else if (state_q == ST_PRESSED && hcnt_q != HCNT_MAX) begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  // An accepted rise always wins over the long-hold transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RELEASED: if (acc_fall) state_d = ST_PRESSED;
      ST_PRESSED: begin
        if (acc_rise) begin
          state_d = ST_RELEASED;
`ifdef NMI_LONGPRESS_EN
        end else if (hold_done) begin
          state_d = ST_LONG;
`endif
        end
      end
`ifdef NMI_LONGPRESS_EN
      ST_LONG: if (acc_rise) state_d = ST_RELEASED;
`endif
      default: state_d = ST_RELEASED;
    endcase
  end

  always_comb begin
    press_pulse_d   = (state_q == ST_RELEASED) && acc_fall;
    release_pulse_d = (state_q != ST_RELEASED) && acc_rise;
`ifdef NMI_LONGPRESS_EN
    mrst_req_n_d    = (state_d != ST_LONG);
`else
    mrst_req_n_d    = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= 1'b1;
      sync_n_q        <= 1'b1;
      dcnt_q          <= '0;
      nmi_button_n_q  <= 1'b1;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      mrst_req_n_q    <= 1'b1;
    end else begin
      sync1_q         <= sync1_d;
      sync_n_q        <= sync_n_d;
      dcnt_q          <= dcnt_d;
      nmi_button_n_q  <= nmi_button_n_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      mrst_req_n_q    <= mrst_req_n_d;
    end
  end

  assign btn.nmi_button_n  = nmi_button_n_q;
  assign btn.press_pulse   = press_pulse_q;
  assign btn.release_pulse = release_pulse_q;
  assign btn.mrst_req_n    = mrst_req_n_q;

endmodule
